hash_empty_ptr_storage: RTL and testbench
=========================================

Name: hash_empty_ptr_storage

Overview:
Free-list allocator for hash table data-table addresses. Holds every data-table address not currently linked into a bucket chain, and presents one free address at a time to the insert path. The delete path returns addresses to the pool. Its add/take strobes drive the empty_ptr_add/del taps watched by the tables monitor.

Parameters:
ADDR_WIDTH, TABLE_ADDR_WIDTH (hash_table pkg), width of a data-table address
DEPTH, 2**ADDR_WIDTH, number of storable addresses; fixed, not overridable

Ports:
clk_i  in  1  clock
rst_i  in  1  async reset, active-high
srst_i  in  1  sync clear; restarts initialisation
add_empty_ptr_i  in  ADDR_WIDTH  address being freed
add_empty_ptr_en_i  in  1  free strobe
next_empty_ptr_o  out  ADDR_WIDTH  current free address (show-ahead)
next_empty_ptr_val_o  out  1  next_empty_ptr_o valid
next_empty_ptr_rd_ack_i  in  1  consumer takes next_empty_ptr_o this cycle
empty_cnt_o  out  ADDR_WIDTH+1  number of free addresses held
init_done_o  out  1  initial fill complete
overflow_o  out  1  sticky: add while full or during init
underflow_o  out  1  sticky: ack while not valid
double_free_o  out  1  sticky: see Optional Feature; tied 0 when feature absent

Behaviour:
- Storage: DEPTH-entry circular FIFO in a register/distributed-RAM array. wr_ptr and rd_ptr are ADDR_WIDTH wide and wrap naturally. cnt is ADDR_WIDTH+1 wide.
- FSM: INIT -> READY.
  - INIT: one write per cycle of addresses 0,1,...,DEPTH-1 in order; takes DEPTH cycles.
  - On the cycle after the last write: state=READY, init_done_o=1, cnt=DEPTH, wr_ptr=0.
- rst_i (async) or srst_i (sync, takes priority over all other inputs in that cycle):
  - state=INIT, ptrs=0, cnt=0.
  - init_done_o=0, next_empty_ptr_val_o=0.
  - all sticky flags cleared.
  - next_empty_ptr_o reads 0.
  - Both apply mid-operation; all addresses become free again.
- next_empty_ptr_o = mem[rd_ptr], combinational from the array.
- next_empty_ptr_val_o = (state==READY) && (cnt!=0).
- Take: ack && val -> rd_ptr+1, cnt-1, effective next cycle.
- Free: add_en in READY && cnt<DEPTH -> mem[wr_ptr]=addr, wr_ptr+1, cnt+1.
- Take and free in the same cycle: both performed, cnt unchanged.
  - If cnt==0, the freed address becomes valid on the next cycle. There is no same-cycle bypass.
  - If cnt==DEPTH, the free is accepted, because the take frees a slot.
- add_en while cnt==DEPTH without a take, or add_en during INIT: write dropped, overflow_o=1.
- ack while !val: ignored, underflow_o=1.
- Latency: a freed address is visible at the output no earlier than 1 cycle after its strobe, and only once it reaches the head of the FIFO.
- empty_cnt_o is registered and reflects completed operations.

Optional Feature:
Macro HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN.
- Defined:
  - Keep a DEPTH-bit free_mask. Set all ones at INIT completion; it stays 0 during INIT.
  - A take clears the taken address's bit; a free sets the freed address's bit.
  - A free of an address whose bit is already 1 is dropped (no FIFO write) and sets double_free_o.
  - For a free and take of the same address in the same cycle, the take is evaluated first, so the free is legal.
- Undefined: no mask; double_free_o tied 0; every free within capacity is accepted.

Decomposition:
- hash_table package: TABLE_ADDR_WIDTH (already present).
- Add to the package: empty_ptr_state_t enum {EPS_INIT, EPS_READY}.
- One sub-module: hash_ptr_fifo, holding the storage array, ptrs and cnt with wr/rd strobes.
- The top level holds the FSM, init address counter, error flags and the optional mask.

Test Plan:
All scenarios use ADDR_WIDTH=3, DEPTH=8.
1. Reset release, then idle 8 cycles -> init_done_o=1 on cycle 9, empty_cnt_o=8, next_empty_ptr_o=0, val=1.
2. After init, ack on 8 consecutive cycles -> outputs 0..7 in order; then val=0, cnt=0. A 9th ack sets underflow_o=1 and cnt stays 0.
3. With cnt=0, free 5 and 2 on consecutive cycles -> val rises the cycle after the free of 5; output reads 5, then 2 after an ack.
4. With cnt=8, assert add_en(3)+ack together -> cnt stays 8, overflow_o=0. Then add_en(4) alone -> overflow_o=1, cnt=8.
5. Feature on: take address 0, free 0 (accepted), free 0 again -> double_free_o=1, cnt unchanged by the second free. Feature off: the same sequence leaves double_free_o=0 and cnt=9 is impossible, so overflow_o=1.
6. Mid-operation srst_i pulse with cnt=3 -> next cycle val=0, flags clear; after 8 cycles cnt=8 and output restarts at 0.

Source files
------------

// File: rtl/hash_empty_ptr_storage_pkg.sv
// -----------------------------------------------------------------------------
// hash_empty_ptr_storage_pkg
// Shared definitions for the hash table free-address storage.
//   TABLE_ADDR_WIDTH  : width of a data-table address
//   empty_ptr_state_t : free-list allocator states (initial fill / ready)
// -----------------------------------------------------------------------------
package hash_empty_ptr_storage_pkg;

  localparam int TABLE_ADDR_WIDTH = 8;

  typedef enum logic {
    EPS_INIT,
    EPS_READY
  } empty_ptr_state_t;

endpackage

// File: rtl/hash_empty_ptr_storage_if.sv
// -----------------------------------------------------------------------------
// hash_empty_ptr_storage_if
// Handshake bundle between the hash table insert/delete paths and the
// free-address storage.
//   add_empty_ptr          : address being returned to the pool
//   add_empty_ptr_en       : free strobe
//   next_empty_ptr         : current free address (show-ahead)
//   next_empty_ptr_val     : next_empty_ptr is valid
//   next_empty_ptr_rd_ack  : consumer takes next_empty_ptr this cycle
// master = hash table side, slave = storage side.
// -----------------------------------------------------------------------------
interface hash_empty_ptr_storage_if
  import hash_empty_ptr_storage_pkg::*;
#(
  parameter int ADDR_WIDTH = TABLE_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] add_empty_ptr;
  logic                  add_empty_ptr_en;
  logic [ADDR_WIDTH-1:0] next_empty_ptr;
  logic                  next_empty_ptr_val;
  logic                  next_empty_ptr_rd_ack;

  modport master (
    output add_empty_ptr,
    output add_empty_ptr_en,
    output next_empty_ptr_rd_ack,
    input  next_empty_ptr,
    input  next_empty_ptr_val
  );

  modport slave (
    input  add_empty_ptr,
    input  add_empty_ptr_en,
    input  next_empty_ptr_rd_ack,
    output next_empty_ptr,
    output next_empty_ptr_val
  );

endinterface

// File: rtl/hash_empty_ptr_storage_fifo.sv
// -----------------------------------------------------------------------------
// hash_ptr_fifo
// DEPTH-entry circular FIFO of data-table addresses (DEPTH = 2**ADDR_WIDTH).
// Pointers are ADDR_WIDTH wide and wrap naturally; the count is one bit wider
// so that "full" (DEPTH) is representable.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : synchronous clear of pointers and count
//   wr_en_i      : push wr_data_i (caller guarantees room)
//   rd_en_i      : pop head (caller guarantees non-empty)
//   rd_data_o    : head entry, combinational from the array
//   cnt_o        : number of entries held
// -----------------------------------------------------------------------------
module hash_ptr_fifo #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [ADDR_WIDTH-1:0] rd_data_o,
  output logic [ADDR_WIDTH:0]   cnt_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   cnt_q;

  // Storage array is left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en_i) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (rd_en_i) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
      case ({wr_en_i, rd_en_i})
        2'b10:   cnt_q <= cnt_q + (ADDR_WIDTH+1)'(1);
        2'b01:   cnt_q <= cnt_q - (ADDR_WIDTH+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rd_data_o = mem[rd_ptr_q];
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/hash_empty_ptr_storage.sv
// -----------------------------------------------------------------------------
// hash_empty_ptr_storage
// Free-list allocator for hash table data-table addresses. After reset it
// fills itself with every address 0..DEPTH-1, then hands out one free address
// at a time (show-ahead) and accepts freed addresses back.
//   clk_i, rst_i   : clock, async active-high reset
//   srst_i         : synchronous clear, restarts the initial fill
//   ptr_if (slave) : free strobe/address in, next free address/valid out,
//                    consumer read acknowledge in
//   empty_cnt_o    : number of free addresses held (registered)
//   init_done_o    : initial fill complete
//   overflow_o     : sticky, free while full (no take) or during fill
//   underflow_o    : sticky, acknowledge while nothing valid
//   double_free_o  : sticky, free of an address already in the pool
// Optional: define HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN to track a per-address
// free mask and reject double frees; otherwise double_free_o is tied 0.
// -----------------------------------------------------------------------------
module hash_empty_ptr_storage
  import hash_empty_ptr_storage_pkg::*;
#(
  parameter int ADDR_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 srst_i,
  hash_empty_ptr_storage_if.slave ptr_if,
  output logic [ADDR_WIDTH:0]  empty_cnt_o,
  output logic                 init_done_o,
  output logic                 overflow_o,
  output logic                 underflow_o,
  output logic                 double_free_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  empty_ptr_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic [ADDR_WIDTH-1:0] fifo_rd_data;
  logic [ADDR_WIDTH:0]   fifo_cnt;
  logic                  fifo_wr_en;
  logic [ADDR_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_rd_en;
  logic                  full;
  logic                  val;
  logic                  take;
  logic                  free_ok;
  logic                  dup;
  logic                  set_ovf;
  logic                  set_unf;
  logic                  set_dbl;
  logic                  ovf_q;
  logic                  unf_q;

  assign full = (fifo_cnt == DEPTH_CNT);
  assign val  = (state_q == EPS_READY) && (fifo_cnt != '0);

`ifdef HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
  logic [DEPTH-1:0] free_mask_q;
  logic             dbl_q;

  // A free of the address being taken in the same cycle is legal, so the
  // take is applied to the mask before the duplicate test.
  assign dup = free_mask_q[ptr_if.add_empty_ptr] &&
               !(take && (fifo_rd_data == ptr_if.add_empty_ptr));
`else
  assign dup = 1'b0;
`endif

  // State register and initial-fill address counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= EPS_INIT;
      init_addr_q <= '0;
    end else if (srst_i) begin
      state_q     <= EPS_INIT;
      init_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EPS_INIT) begin
        init_addr_q <= init_addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Next state and FIFO strobes. During the fill every cycle writes the
  // next address; once ready, frees need room, which a same-cycle take
  // provides even when full. srst_i masks every strobe.
  always_comb begin
    state_d      = state_q;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = ptr_if.add_empty_ptr;
    fifo_rd_en   = 1'b0;
    take         = 1'b0;
    free_ok      = 1'b0;
    set_ovf      = 1'b0;
    set_unf      = 1'b0;
    set_dbl      = 1'b0;
    case (state_q)
      EPS_INIT: begin
        fifo_wr_en   = 1'b1;
        fifo_wr_data = init_addr_q;
        set_ovf      = ptr_if.add_empty_ptr_en;
        if (&init_addr_q) begin
          state_d = EPS_READY;
        end
      end
      EPS_READY: begin
        take       = ptr_if.next_empty_ptr_rd_ack && val;
        fifo_rd_en = take;
        free_ok    = ptr_if.add_empty_ptr_en && (!full || take) && !dup;
        fifo_wr_en = free_ok;
        set_ovf    = ptr_if.add_empty_ptr_en && full && !take;
        set_dbl    = ptr_if.add_empty_ptr_en && dup;
      end
      default: state_d = EPS_INIT;
    endcase
    set_unf = ptr_if.next_empty_ptr_rd_ack && !val;
    if (srst_i) begin
      state_d    = EPS_INIT;
      fifo_wr_en = 1'b0;
      fifo_rd_en = 1'b0;
      take       = 1'b0;
      free_ok    = 1'b0;
      set_ovf    = 1'b0;
      set_unf    = 1'b0;
      set_dbl    = 1'b0;
    end
  end

  // Sticky error flags, cleared only by a reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (srst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | set_ovf;
      unf_q <= unf_q | set_unf;
    end
  end

`ifdef HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
  // Free mask: empty during the fill, all ones on the fill's last cycle,
  // then cleared on take and set on accepted free (take applied first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_mask_q <= '0;
      dbl_q       <= 1'b0;
    end else if (srst_i) begin
      free_mask_q <= '0;
      dbl_q       <= 1'b0;
    end else begin
      dbl_q <= dbl_q | set_dbl;
      if (state_q == EPS_INIT) begin
        if (&init_addr_q) begin
          free_mask_q <= '1;
        end
      end else begin
        if (take) begin
          free_mask_q[fifo_rd_data] <= 1'b0;
        end
        if (free_ok) begin
          free_mask_q[ptr_if.add_empty_ptr] <= 1'b1;
        end
      end
    end
  end

  assign double_free_o = dbl_q;
`else
  assign double_free_o = 1'b0;
`endif

  hash_ptr_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (srst_i),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i (fifo_wr_data),
    .rd_en_i   (fifo_rd_en),
    .rd_data_o (fifo_rd_data),
    .cnt_o     (fifo_cnt)
  );

  // Output reads 0 until the pool is ready so a cleared table shows no
  // stale head.
  assign ptr_if.next_empty_ptr     = (state_q == EPS_READY) ? fifo_rd_data : '0;
  assign ptr_if.next_empty_ptr_val = val;
  assign empty_cnt_o               = fifo_cnt;
  assign init_done_o               = (state_q == EPS_READY);
  assign overflow_o                = ovf_q;
  assign underflow_o               = unf_q;

  logic unused_set_dbl;
  assign unused_set_dbl = set_dbl;

endmodule

// File: tb/tb_hash_empty_ptr_storage.sv
// -----------------------------------------------------------------------------
// tb_hash_empty_ptr_storage
// Directed bench for hash_empty_ptr_storage with ADDR_WIDTH=3 (DEPTH=8).
// A queue model of the free pool predicts the address handed out on every
// take; counts and sticky flags are predicted alongside it.
// -----------------------------------------------------------------------------
module tb_hash_empty_ptr_storage;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          srst_i;
  logic [AW:0]   empty_cnt_o;
  logic          init_done_o;
  logic          overflow_o;
  logic          underflow_o;
  logic          double_free_o;

  hash_empty_ptr_storage_if #(.ADDR_WIDTH(AW)) ptr_if ();

  hash_empty_ptr_storage #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .srst_i        (srst_i),
    .ptr_if        (ptr_if),
    .empty_cnt_o   (empty_cnt_o),
    .init_done_o   (init_done_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o),
    .double_free_o (double_free_o)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  int mq[$];
  bit m_ready;
  int init_cycles;
  bit m_ovf, m_unf, m_dbl;
  bit [DEPTH-1:0] m_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mq.delete();
    m_ready     = 1'b0;
    init_cycles = 0;
    m_ovf       = 1'b0;
    m_unf       = 1'b0;
    m_dbl       = 1'b0;
    m_mask      = '0;
  endtask

  // One clock cycle of stimulus; the model is updated from the same inputs.
  task automatic applyStimulus(input bit en, input int addr, input bit ack);
    int  size_before;
    bit  m_val, take, room, dup;
    int  exp_addr;
    @(negedge clk_i);
    srst_i                       = 1'b0;
    ptr_if.add_empty_ptr_en      = en;
    ptr_if.add_empty_ptr         = AW'(addr);
    ptr_if.next_empty_ptr_rd_ack = ack;
    #1;
    size_before = mq.size();
    m_val = m_ready && (size_before != 0);
    take  = ack && m_val;
    if (take) begin
      exp_addr = mq.pop_front();
      chk("take_data", 32'(ptr_if.next_empty_ptr), exp_addr);
`ifdef HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
      m_mask[exp_addr] = 1'b0;
`endif
    end
    if (ack && !m_val) m_unf = 1'b1;
    if (en) begin
      if (!m_ready) begin
        m_ovf = 1'b1;
      end else begin
        room = (size_before < DEPTH) || take;
        dup  = 1'b0;
`ifdef HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
        dup = m_mask[addr];
        if (dup) m_dbl = 1'b1;
`endif
        if (!room) m_ovf = 1'b1;
        if (room && !dup) begin
          mq.push_back(addr);
`ifdef HASH_EMPTY_PTR_DOUBLE_FREE_CHECK_EN
          m_mask[addr] = 1'b1;
`endif
        end
      end
    end
    @(posedge clk_i);
    if (!m_ready) begin
      init_cycles++;
      if (init_cycles == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mq.push_back(i);
        m_mask = '1;
      end
    end
  endtask

  task automatic applySyncClear();
    @(negedge clk_i);
    srst_i                       = 1'b1;
    ptr_if.add_empty_ptr_en      = 1'b0;
    ptr_if.next_empty_ptr_rd_ack = 1'b0;
    @(posedge clk_i);
    resetModel();
  endtask

  // Compare all outputs against the model, 1 time unit after the edge.
  task automatic checkOutput(input string tag);
    int exp_cnt;
    bit exp_val;
    #1;
    exp_val = m_ready && (mq.size() != 0);
    exp_cnt = m_ready ? mq.size() : init_cycles;
    chk({tag, ".val"},       32'(ptr_if.next_empty_ptr_val), 32'(exp_val));
    chk({tag, ".cnt"},       32'(empty_cnt_o), exp_cnt);
    chk({tag, ".init_done"}, 32'(init_done_o), 32'(m_ready));
    chk({tag, ".overflow"},  32'(overflow_o), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow_o), 32'(m_unf));
    chk({tag, ".dbl_free"},  32'(double_free_o), 32'(m_dbl));
    if (exp_val) chk({tag, ".head"}, 32'(ptr_if.next_empty_ptr), mq[0]);
    else if (!m_ready) chk({tag, ".head0"}, 32'(ptr_if.next_empty_ptr), 0);
  endtask

  initial begin
    rst_i                        = 1'b1;
    srst_i                       = 1'b0;
    ptr_if.add_empty_ptr_en      = 1'b0;
    ptr_if.add_empty_ptr         = '0;
    ptr_if.next_empty_ptr_rd_ack = 1'b0;
    resetModel();

    // Reset state, then release just after an edge.
    repeat (2) @(posedge clk_i);
    checkOutput("reset");
    #1 rst_i = 1'b0;

    // Initial fill: ready with 8 free addresses after 8 cycles.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("init");
    end
    chk("init.done_cnt", 32'(empty_cnt_o), 8);

    // Drain all 8 in order, then one more ack underflows.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b1);
      checkOutput("drain");
    end
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("underflow");

    // Free into an empty pool; valid only on the following cycle.
    applyStimulus(1'b1, 5, 1'b0);
    checkOutput("free5");
    applyStimulus(1'b1, 2, 1'b0);
    checkOutput("free2");
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("take5");

    // Bring to 3 entries, then sync clear mid-operation and refill.
    applyStimulus(1'b1, 6, 1'b0);
    applyStimulus(1'b1, 7, 1'b0);
    checkOutput("cnt3");
    applySyncClear();
    checkOutput("srst");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("refill");
    end

    // Full pool: free plus take together is accepted, free alone overflows.
    applyStimulus(1'b1, 0, 1'b1);
    checkOutput("full_swap");
    applyStimulus(1'b1, 4, 1'b0);
    checkOutput("full_ovf");

    // Double free sequence from a fresh pool.
    applySyncClear();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("refill2");
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("take0");
    applyStimulus(1'b1, 0, 1'b0);
    checkOutput("free0");
    applyStimulus(1'b1, 0, 1'b0);
    checkOutput("free0_again");

    // Free during the fill is dropped and flagged.
    applySyncClear();
    applyStimulus(1'b1, 3, 1'b0);
    checkOutput("init_free");
    for (int i = 1; i < DEPTH; i++) applyStimulus(1'b0, 0, 1'b0);
    checkOutput("refill3");

    // Mixed random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                    1'($urandom_range(0, 1)));
      checkOutput("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
